// File: rtl/wb_uart_sequencer.sv
// Wishbone master that initialises a 16550 UART and then forwards client bytes.
// Ports: wb_clk_i/wb_rst_i, wbm_* master bus, tx_* byte handshake, init_done_o/err_o.
// Optional: WB_UART_SEQUENCER_TIMEOUT_EN enables the bus-cycle timeout counter.
module wb_uart_sequencer #(
   parameter logic [31:0] UART_BASE = 32'h9000_0000,
   parameter logic [15:0] DIVISOR   = 16'd27,
   parameter logic [7:0]  LCR_VAL   = 8'h03,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   output logic [31:0] wbm_adr_o,
   output logic [7:0]  wbm_dat_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic [7:0]  wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic        init_done_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      INIT_DLAB, INIT_DLL, INIT_DLM, INIT_LCR, INIT_FCR,
      IDLE, POLL_LSR, WR_THR, GAP, ERROR
   } state_e;

   state_e      state_q, state_d;
   state_e      ret_q, ret_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic [7:0]  byte_q, byte_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic        is_acc;
   logic [2:0]  acc_off;
   logic [7:0]  acc_dat;
   logic        acc_we;
   state_e      acc_next;

`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_q, tmo_d;
`else
   localparam int unsigned unused_timeout = TIMEOUT;
`endif

   // Only the THRE bit of the LSR matters to this sequencer.
   logic unused_dat;
   assign unused_dat = ^{wbm_dat_i[7:6], wbm_dat_i[4:0]};

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= INIT_DLAB;
         ret_q   <= INIT_DLAB;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= UART_BASE;
         dat_q   <= 8'h00;
         byte_q  <= 8'h00;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         byte_q  <= byte_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      byte_d   = byte_q;
      done_d   = done_q;
      err_d    = err_q;
`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      is_acc   = 1'b0;
      acc_off  = 3'd0;
      acc_dat  = 8'h00;
      acc_we   = 1'b1;
      acc_next = IDLE;

      unique case (state_q)
         INIT_DLAB: begin
            is_acc   = 1'b1;
            acc_off  = 3'd3;
            acc_dat  = LCR_VAL | 8'h80;
            acc_next = INIT_DLL;
         end
         INIT_DLL: begin
            is_acc   = 1'b1;
            acc_off  = 3'd0;
            acc_dat  = DIVISOR[7:0];
            acc_next = INIT_DLM;
         end
         INIT_DLM: begin
            is_acc   = 1'b1;
            acc_off  = 3'd1;
            acc_dat  = DIVISOR[15:8];
            acc_next = INIT_LCR;
         end
         INIT_LCR: begin
            is_acc   = 1'b1;
            acc_off  = 3'd3;
            acc_dat  = LCR_VAL;
            acc_next = INIT_FCR;
         end
         INIT_FCR: begin
            is_acc   = 1'b1;
            acc_off  = 3'd2;
            acc_dat  = 8'h07;
            acc_next = IDLE;
         end
         IDLE: begin
            if (tx_valid_i) begin
               byte_d  = tx_data_i;
               state_d = POLL_LSR;
            end
         end
         POLL_LSR: begin
            is_acc   = 1'b1;
            acc_off  = 3'd5;
            acc_we   = 1'b0;
            acc_next = wbm_dat_i[5] ? WR_THR : POLL_LSR;
         end
         WR_THR: begin
            is_acc   = 1'b1;
            acc_off  = 3'd0;
            acc_dat  = byte_q;
            acc_next = IDLE;
         end
         GAP: state_d = ret_q;
         ERROR: state_d = ERROR;
         default: state_d = ERROR;
      endcase

      // Access states launch on entry (cyc low), then hold until terminated.
      if (is_acc) begin
         if (!cyc_q) begin
            cyc_d = 1'b1;
            adr_d = UART_BASE + {29'd0, acc_off};
            dat_d = acc_dat;
            we_d  = acc_we;
`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
            tmo_d = '0;
`endif
         end else if (wbm_err_i) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ERROR;
         end else if (wbm_ack_i) begin
            cyc_d = 1'b0;
            if (state_q == INIT_FCR) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = GAP;
               ret_d   = acc_next;
            end
         end else if (wbm_rty_i) begin
            cyc_d   = 1'b0;
            state_d = GAP;
            ret_d   = state_q;
`ifdef WB_UART_SEQUENCER_TIMEOUT_EN
         end else if (tmo_q == TMO_LAST) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            state_d = ERROR;
         end else begin
            tmo_d = tmo_q + 1'b1;
`endif
         end
      end
   end

   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign wbm_we_o    = we_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_cti_o   = 3'b000;
   assign wbm_bte_o   = 2'b00;
   assign tx_ready_o  = (state_q == IDLE);
   assign init_done_o = done_q;
   assign err_o       = err_q;

endmodule
